// File: rtl/redmule_cfg_slave.sv
// Configuration slave for the RedMulE engine: staged job registers, trigger/commit, and status.
// Define REDMULE_CFG_READBACK_EN to make STAGE registers readable.
module redmule_cfg_slave #(
  parameter int unsigned NumCfgRegs = 6,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned IdWidth    = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            clear_i,
  input  logic                            req_i,
  input  logic                            wen_i,
  input  logic [DataWidth/8-1:0]          be_i,
  input  logic [31:0]                     add_i,
  input  logic [DataWidth-1:0]            data_i,
  input  logic [IdWidth-1:0]              id_i,
  output logic                            gnt_o,
  output logic                            r_valid_o,
  output logic [DataWidth-1:0]            r_data_o,
  output logic [IdWidth-1:0]              r_id_o,
  output logic                            cfg_complete_o,
  output logic [NumCfgRegs*DataWidth-1:0] job_regs_o,
  output logic                            job_valid_o,
  input  logic                            job_ready_i,
  input  logic                            busy_i
);

  localparam int unsigned NumBytes = DataWidth / 8;

  logic [NumCfgRegs*DataWidth-1:0] stage_q;
  logic [NumCfgRegs*DataWidth-1:0] job_regs_q;
  logic [NumCfgRegs-1:0]           mask_q;
  logic [NumCfgRegs-1:0]           stage_sel;
  logic                            job_valid_q;
  logic                            err_q;
  logic                            r_valid_q;
  logic [DataWidth-1:0]            r_data_q;
  logic [IdWidth-1:0]              r_id_q;

  logic is_trig, is_status, stall, do_write, do_read, commit, trig_err;
  logic [DataWidth-1:0] rdata;

  always_comb begin
    stage_sel = '0;
    for (int unsigned i = 0; i < NumCfgRegs; i++) begin
      stage_sel[i] = (add_i == 32'h40 + 32'(4 * i));
    end
  end

  assign is_trig        = (add_i == 32'h0);
  assign is_status      = (add_i == 32'h4);
  assign cfg_complete_o = &mask_q;

  // A trigger cannot be accepted while the engine still owes us a handshake.
  assign stall    = req_i & ~wen_i & is_trig & job_valid_q & ~job_ready_i;
  assign gnt_o    = req_i & ~stall;
  assign do_write = gnt_o & ~wen_i;
  assign do_read  = gnt_o & wen_i;
  assign commit   = do_write & is_trig & cfg_complete_o;
  assign trig_err = do_write & is_trig & ~cfg_complete_o;

  always_comb begin
    rdata = '0;
    if (do_read) begin
      if (is_status) begin
        rdata[0]              = job_valid_q;
        rdata[1]              = busy_i;
        rdata[2]              = err_q;
        rdata[8 +: NumCfgRegs] = mask_q;
      end
`ifdef REDMULE_CFG_READBACK_EN
      for (int unsigned i = 0; i < NumCfgRegs; i++) begin
        if (stage_sel[i]) rdata = stage_q[i*DataWidth +: DataWidth];
      end
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q     <= '0;
      job_regs_q  <= '0;
      mask_q      <= '0;
      job_valid_q <= 1'b0;
      err_q       <= 1'b0;
      r_valid_q   <= 1'b0;
      r_data_q    <= '0;
      r_id_q      <= '0;
    end else if (clear_i) begin
      stage_q     <= '0;
      job_regs_q  <= '0;
      mask_q      <= '0;
      job_valid_q <= 1'b0;
      err_q       <= 1'b0;
      r_valid_q   <= 1'b0;
      r_data_q    <= '0;
      r_id_q      <= '0;
    end else begin
      r_valid_q <= gnt_o;
      if (gnt_o) begin
        r_data_q <= rdata;
        r_id_q   <= id_i;
      end
      for (int unsigned i = 0; i < NumCfgRegs; i++) begin
        if (do_write && stage_sel[i]) begin
          mask_q[i] <= 1'b1;
          for (int unsigned b = 0; b < NumBytes; b++) begin
            if (be_i[b]) stage_q[i*DataWidth + b*8 +: 8] <= data_i[b*8 +: 8];
          end
        end
      end
      // Commit takes priority over the engine handshake in the same cycle.
      if (commit) begin
        job_regs_q  <= stage_q;
        job_valid_q <= 1'b1;
        mask_q      <= '0;
      end else if (job_valid_q && job_ready_i) begin
        job_valid_q <= 1'b0;
      end
      if (trig_err) begin
        err_q <= 1'b1;
      end else if (do_read && is_status) begin
        err_q <= 1'b0;
      end
    end
  end

  assign r_valid_o   = r_valid_q;
  assign r_data_o    = r_data_q;
  assign r_id_o      = r_id_q;
  assign job_regs_o  = job_regs_q;
  assign job_valid_o = job_valid_q;

endmodule

// File: tb/tb_redmule_cfg_slave.sv
// Scoreboard bench for redmule_cfg_slave: responses are queued at grant and matched on r_valid_o.
module tb_redmule_cfg_slave;
  localparam int unsigned N  = 6;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 1;
`ifdef REDMULE_CFG_READBACK_EN
  localparam bit Rb = 1'b1;
`else
  localparam bit Rb = 1'b0;
`endif

  logic          clk_i = 1'b0, rst_ni = 1'b0, clear_i = 1'b0;
  logic          req_i = 1'b0, wen_i = 1'b0;
  logic [DW/8-1:0] be_i = '0;
  logic [31:0]   add_i = '0;
  logic [DW-1:0] data_i = '0;
  logic [IW-1:0] id_i = '0;
  logic          job_ready_i = 1'b0, busy_i = 1'b0;
  logic          gnt_o, r_valid_o, cfg_complete_o, job_valid_o;
  logic [DW-1:0] r_data_o;
  logic [IW-1:0] r_id_o;
  logic [N*DW-1:0] job_regs_o;

  redmule_cfg_slave #(.NumCfgRegs(N), .DataWidth(DW), .IdWidth(IW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .req_i(req_i), .wen_i(wen_i),
    .be_i(be_i), .add_i(add_i), .data_i(data_i), .id_i(id_i), .gnt_o(gnt_o),
    .r_valid_o(r_valid_o), .r_data_o(r_data_o), .r_id_o(r_id_o),
    .cfg_complete_o(cfg_complete_o), .job_regs_o(job_regs_o), .job_valid_o(job_valid_o),
    .job_ready_i(job_ready_i), .busy_i(busy_i)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; } rsp_t;
  rsp_t sb[$];
  logic [DW-1:0] stage_m [N];
  logic [N*DW-1:0] exp_regs;

  task automatic check(input string tag, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Responses must arrive exactly one cycle after grant.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (sb.size() > 0) begin
        rsp_t e;
        e = sb.pop_front();
        check("rsp_valid", N*DW'(r_valid_o), N*DW'(1'b1));
        check("rsp_id", N*DW'(r_id_o), N*DW'(e.id));
        check("rsp_data", N*DW'(r_data_o), N*DW'(e.data));
      end else begin
        check("idle_rvalid", N*DW'(r_valid_o), '0);
      end
    end
  end

  task automatic bus(input logic rd, input logic [31:0] addr, input logic [DW-1:0] wdata,
                     input logic [DW/8-1:0] be, input logic [IW-1:0] id, input logic [DW-1:0] exp_rd);
    int waited;
    waited = 0;
    @(negedge clk_i);
    req_i = 1'b1; wen_i = rd; add_i = addr; data_i = wdata; be_i = be; id_i = id;
    #1;
    while (!gnt_o && waited < 20) begin
      @(negedge clk_i); #1; waited++;
    end
    if (!gnt_o) begin
      check("gnt_timeout", '0, N*DW'(1'b1));
    end else begin
      sb.push_back('{id: id, data: rd ? exp_rd : '0});
      if (!rd) begin
        for (int i = 0; i < int'(N); i++) begin
          if (addr == 32'h40 + 32'(4 * i)) begin
            for (int b = 0; b < int'(DW/8); b++) begin
              if (be[b]) stage_m[i][b*8 +: 8] = wdata[b*8 +: 8];
            end
          end
        end
      end
    end
    @(posedge clk_i); #1;
    req_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [DW-1:0] wdata);
    bus(1'b0, addr, wdata, '1, '0, '0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [IW-1:0] id, input logic [DW-1:0] exp_rd);
    bus(1'b1, addr, '0, '1, id, exp_rd);
  endtask

  task automatic snap();
    for (int i = 0; i < int'(N); i++) exp_regs[i*DW +: DW] = stage_m[i];
  endtask

  initial begin
    for (int i = 0; i < int'(N); i++) stage_m[i] = '0;
    req_i = 1'b1;
    #3;
    check("rst_gnt", N*DW'(gnt_o), N*DW'(1'b1));
    check("rst_rvalid", N*DW'(r_valid_o), '0);
    check("rst_rdata", N*DW'(r_data_o), '0);
    check("rst_rid", N*DW'(r_id_o), '0);
    check("rst_complete", N*DW'(cfg_complete_o), '0);
    check("rst_jobvalid", N*DW'(job_valid_o), '0);
    check("rst_jobregs", job_regs_o, '0);
    req_i = 1'b0;
    @(negedge clk_i); rst_ni = 1'b1;

    // Full staging then trigger
    for (int i = 0; i < int'(N); i++) wr(32'h40 + 32'(4 * i), DW'(i + 1));
    check("complete_set", N*DW'(cfg_complete_o), N*DW'(1'b1));
    snap();
    wr(32'h0, '0);
    check("commit_valid", N*DW'(job_valid_o), N*DW'(1'b1));
    check("commit_regs", job_regs_o, exp_regs);
    check("commit_clr", N*DW'(cfg_complete_o), '0);
    busy_i = 1'b1;
    rd(32'h4, '0, 32'h3);
    busy_i = 1'b0;

    // Stage during pending job, trigger stalls until ready
    for (int i = 0; i < int'(N); i++) wr(32'h40 + 32'(4 * i), DW'(32'h10 + i));
    snap();
    @(negedge clk_i);
    req_i = 1'b1; wen_i = 1'b0; add_i = 32'h0; data_i = '0; be_i = '1; id_i = '0;
    for (int k = 0; k < 3; k++) begin
      #1; check("stall_gnt", N*DW'(gnt_o), '0);
      @(negedge clk_i);
    end
    job_ready_i = 1'b1;
    #1; check("release_gnt", N*DW'(gnt_o), N*DW'(1'b1));
    sb.push_back('{id: '0, data: '0});
    @(posedge clk_i); #1;
    req_i = 1'b0; job_ready_i = 1'b0;
    check("stall_commit_valid", N*DW'(job_valid_o), N*DW'(1'b1));
    check("stall_commit_regs", job_regs_o, exp_regs);

    // Engine handshake drops the job
    @(negedge clk_i); job_ready_i = 1'b1;
    @(posedge clk_i); #1; job_ready_i = 1'b0;
    check("ack_clears", N*DW'(job_valid_o), '0);

    // Commit while handshake completes in the same cycle
    for (int i = 0; i < int'(N); i++) wr(32'h40 + 32'(4 * i), DW'(32'h20 + i));
    wr(32'h0, '0);
    for (int i = 0; i < int'(N); i++) wr(32'h40 + 32'(4 * i), DW'(32'h30 + i));
    snap();
    job_ready_i = 1'b1;
    wr(32'h0, '0);
    job_ready_i = 1'b0;
    check("same_cycle_valid", N*DW'(job_valid_o), N*DW'(1'b1));
    check("same_cycle_regs", job_regs_o, exp_regs);
    @(negedge clk_i); job_ready_i = 1'b1;
    @(posedge clk_i); #1; job_ready_i = 1'b0;

    // Incomplete trigger sets the sticky error
    for (int i = 0; i < 5; i++) wr(32'h40 + 32'(4 * i), DW'(32'h40 + i));
    wr(32'h0, '0);
    check("err_no_commit", N*DW'(job_valid_o), '0);
    check("err_regs_kept", job_regs_o, exp_regs);
    rd(32'h4, '0, 32'h1F04);
    rd(32'h4, '0, 32'h1F00);

    // Partial byte-enable write
    wr(32'h40, '0);
    bus(1'b0, 32'h40, 32'hAABBCCDD, 4'b0011, '0, '0);
    rd(32'h40, '0, Rb ? 32'h0000CCDD : 32'h0);
    rd(32'h54, '1, Rb ? 32'h35 : 32'h0);

    // Unmapped and TRIGGER reads, ignored unmapped write
    rd(32'h80, 1'b1, '0);
    rd(32'h0, 1'b1, '0);
    wr(32'h84, '1);
    wr(32'h42, '1);
    rd(32'h4, '0, 32'h1F00);

    // Complete set, commit, then soft clear with a job pending
    wr(32'h54, 32'h55);
    snap();
    wr(32'h0, '0);
    check("final_commit_regs", job_regs_o, exp_regs);
    @(negedge clk_i);
    clear_i = 1'b1; req_i = 1'b1; wen_i = 1'b1; add_i = 32'h4; id_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0; req_i = 1'b0;
    for (int i = 0; i < int'(N); i++) stage_m[i] = '0;
    check("clear_jobvalid", N*DW'(job_valid_o), '0);
    check("clear_jobregs", job_regs_o, '0);
    check("clear_complete", N*DW'(cfg_complete_o), '0);
    rd(32'h4, '0, '0);

    // Reset mid-transaction discards the response
    wr(32'h40, 32'h77);
    @(negedge clk_i);
    req_i = 1'b1; wen_i = 1'b1; add_i = 32'h4; id_i = 1'b1;
    #2; rst_ni = 1'b0;
    #1; req_i = 1'b0;
    @(posedge clk_i); #1;
    check("rst_mid_rvalid", N*DW'(r_valid_o), '0);
    @(negedge clk_i); rst_ni = 1'b1;
    for (int i = 0; i < int'(N); i++) stage_m[i] = '0;
    rd(32'h4, '0, '0);
    rd(32'h40, '0, '0);

    repeat (3) @(negedge clk_i);
    check("sb_empty", N*DW'(sb.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
